// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared state, interval-code and lamp definitions for the intersection
package tl_pkg;

    typedef enum logic [3:0] {
        ST_INIT        = 4'd0,
        ST_MAIN_GREEN  = 4'd1,
        ST_MAIN_YELLOW = 4'd2,
        ST_ALL_RED_A   = 4'd3,
        ST_WALK        = 4'd4,
        ST_SIDE_GREEN  = 4'd5,
        ST_SIDE_YELLOW = 4'd6,
        ST_ALL_RED_B   = 4'd7
    } state_e;

    typedef enum logic [1:0] {
        IV_BASE   = 2'b00,
        IV_EXT    = 2'b01,
        IV_YEL    = 2'b10,
        IV_ALLRED = 2'b11
    } interval_e;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

endpackage

// File: rtl/req_sync.sv
// rtl/req_sync.sv - multi-flop synchroniser for an asynchronous request, level or rising-edge output
module req_sync #(
    parameter int STAGES  = 2,
    parameter bit RISE_EN = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic req_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
        end
    end

    generate
        if (RISE_EN) begin : g_rise
            logic prev_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_q <= 1'b0;
                end else begin
                    prev_q <= sync_q[STAGES-1];
                end
            end
            assign req_o = sync_q[STAGES-1] & ~prev_q;
        end else begin : g_level
            assign req_o = sync_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/traffic_phase_sequencer.sv
// rtl/traffic_phase_sequencer.sv - intersection master FSM driving the phase timer and lamps
module traffic_phase_sequencer
    import tl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit WALK_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic       sensor,
    input  logic       walk_btn,
    input  logic       expired,
    output logic [1:0] interval_sel,
    output logic       start_timer,
    output logic [2:0] main_lamp,
    output logic [2:0] side_lamp,
    output logic       walk_lamp
);

    state_e    state_q, state_d;
    interval_e interval_q, interval_d;
    logic [2:0] main_q, main_d, side_q, side_d;
    logic       walk_lamp_q, walk_lamp_d;
    logic       sensor_l_q, sensor_l_d, walk_l_q, walk_l_d;
    logic       ext_used_q, ext_used_d;
    logic       arm_q, arm_d, start_q;
    logic [1:0] blank_q, blank_d;
    logic       rearm, extend, accept, enter_sg, enter_walk;
    logic       sensor_s, walk_rise;

    req_sync #(.STAGES(SYNC_STAGES), .RISE_EN(1'b0)) u_sensor_sync (
        .clk     (clk),
        .rst_n   (Reset_n),
        .async_i (sensor),
        .req_o   (sensor_s)
    );

    req_sync #(.STAGES(SYNC_STAGES), .RISE_EN(1'b1)) u_walk_sync (
        .clk     (clk),
        .rst_n   (Reset_n),
        .async_i (walk_btn),
        .req_o   (walk_rise)
    );

    // Expiry is only honoured once the timer has been started and has had time to load.
    assign accept = expired && !arm_q && !start_q && (blank_q == 2'd0);

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_INIT;
            interval_q  <= IV_ALLRED;
            main_q      <= LAMP_R;
            side_q      <= LAMP_R;
            walk_lamp_q <= 1'b0;
            sensor_l_q  <= 1'b0;
            walk_l_q    <= 1'b0;
            ext_used_q  <= 1'b0;
            arm_q       <= 1'b1;
            start_q     <= 1'b0;
            blank_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            interval_q  <= interval_d;
            main_q      <= main_d;
            side_q      <= side_d;
            walk_lamp_q <= walk_lamp_d;
            sensor_l_q  <= sensor_l_d;
            walk_l_q    <= walk_l_d;
            ext_used_q  <= ext_used_d;
            arm_q       <= arm_d;
            start_q     <= arm_q;
            blank_q     <= blank_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rearm   = 1'b0;
        extend  = 1'b0;
        case (state_q)
            ST_INIT:        if (accept) state_d = ST_MAIN_GREEN;
            ST_MAIN_GREEN:  if (accept) begin
                                if (sensor_l_q || walk_l_q) state_d = ST_MAIN_YELLOW;
                                else                        rearm   = 1'b1;
                            end
            ST_MAIN_YELLOW: if (accept) state_d = ST_ALL_RED_A;
            ST_ALL_RED_A:   if (accept) state_d = (walk_l_q && WALK_EN) ? ST_WALK : ST_SIDE_GREEN;
            ST_WALK:        if (accept) state_d = sensor_l_q ? ST_SIDE_GREEN : ST_ALL_RED_B;
            ST_SIDE_GREEN:  if (accept) begin
                                if (sensor_s && !ext_used_q) begin
                                    rearm  = 1'b1;
                                    extend = 1'b1;
                                end else begin
                                    state_d = ST_SIDE_YELLOW;
                                end
                            end
            ST_SIDE_YELLOW: if (accept) state_d = ST_ALL_RED_B;
            ST_ALL_RED_B:   if (accept) state_d = ST_MAIN_GREEN;
            default:        state_d = ST_INIT;
        endcase
    end

    assign enter_sg   = (state_d == ST_SIDE_GREEN) && (state_q != ST_SIDE_GREEN);
    assign enter_walk = (state_d == ST_WALK) && (state_q != ST_WALK);

    // Setting a latch takes priority over clearing it so a request arriving on entry is kept.
    assign sensor_l_d = sensor_s | (sensor_l_q & ~enter_sg);
    assign walk_l_d   = WALK_EN & (walk_rise | (walk_l_q & ~enter_walk));
    assign ext_used_d = extend ? 1'b1 : (enter_sg ? 1'b0 : ext_used_q);
    assign arm_d      = (state_d != state_q) | rearm;
    assign blank_d    = start_q ? 2'd2 : ((blank_q != 2'd0) ? blank_q - 2'd1 : 2'd0);

    always_comb begin
        interval_d  = IV_ALLRED;
        main_d      = LAMP_R;
        side_d      = LAMP_R;
        walk_lamp_d = 1'b0;
        case (state_d)
            ST_MAIN_GREEN:  begin interval_d = IV_BASE; main_d = LAMP_G; end
            ST_MAIN_YELLOW: begin interval_d = IV_YEL;  main_d = LAMP_Y; end
            ST_WALK:        begin interval_d = IV_BASE; walk_lamp_d = WALK_EN; end
            ST_SIDE_GREEN:  begin
                                interval_d = ext_used_d ? IV_EXT : IV_BASE;
                                side_d     = LAMP_G;
                            end
            ST_SIDE_YELLOW: begin interval_d = IV_YEL;  side_d = LAMP_Y; end
            default:        ;
        endcase
    end

    assign interval_sel = interval_q;
    assign start_timer  = start_q;
    assign main_lamp    = main_q;
    assign side_lamp    = side_q;
    assign walk_lamp    = walk_lamp_q;

endmodule
